// File: rtl/song_pkg.sv
// song_pkg: state type, note codes, end marker, entry struct and the song table
// shared by song_sequencer and song_rom.
package song_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    localparam int ENT_NOTE_W = 4;
    localparam int ENT_DUR_W  = 4;

    typedef logic [ENT_NOTE_W-1:0] note_t;
    typedef logic [ENT_DUR_W-1:0]  dur_t;

    localparam note_t REST = 4'd0;
    localparam note_t DO   = 4'd1;
    localparam note_t RE   = 4'd2;
    localparam note_t MI   = 4'd3;
    localparam note_t FA   = 4'd4;
    localparam note_t SOL  = 4'd5;
    localparam note_t LA   = 4'd6;
    localparam note_t SI   = 4'd7;
    localparam note_t HDO  = 4'd8;
    localparam note_t HRE  = 4'd9;
    localparam note_t HMI  = 4'd10;
    localparam note_t HFA  = 4'd11;
    localparam note_t HSOL = 4'd12;
    localparam note_t HLA  = 4'd13;
    localparam note_t HSI  = 4'd14;

    localparam dur_t END_MARK = 4'd0;

    typedef struct packed {
        note_t note;
        dur_t  dur;
    } song_entry_t;

    // Anything not listed reads back as an end marker.
    function automatic song_entry_t song_entry(input logic [31:0] song, input logic [31:0] idx);
        song_entry_t e;
        e = '{note: REST, dur: END_MARK};
        case (song)
            0: case (idx)
                0: e = '{note: DO, dur: 4'd2};
                1: e = '{note: MI, dur: 4'd1};
                default: ;
            endcase
            1: if (idx < 16) e = '{note: note_t'((idx % 14) + 1), dur: dur_t'((idx % 2) + 1)};
            3: case (idx)
                0: e = '{note: SOL, dur: 4'd1};
                1: e = '{note: REST, dur: 4'd2};
                2: e = '{note: HDO, dur: 4'd1};
                default: ;
            endcase
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: synchronous-read song table addressed by {song, index}; contents
// come from song_pkg::song_entry.
module song_rom
    import song_pkg::*;
#(
    parameter int NOTE_W   = 4,
    parameter int DUR_W    = 4,
    parameter int SONG_CNT = 4,
    parameter int SONG_LEN = 16
) (
    input  logic                        clk,
    input  logic [$clog2(SONG_CNT)-1:0] song,
    input  logic [$clog2(SONG_LEN)-1:0] idx,
    output logic [NOTE_W-1:0]           rd_note,
    output logic [DUR_W-1:0]            rd_dur
);

    song_entry_t e;

    always_comb e = song_entry(32'(song), 32'(idx));

    always_ff @(posedge clk) begin
        rd_note <= NOTE_W'(e.note);
        rd_dur  <= DUR_W'(e.dur);
    end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: steps through a stored song timing each note in beats, with
// pause/stop and an end-of-song pulse. Define SONG_SEQUENCER_LOOP_EN to repeat the song.
module song_sequencer
    import song_pkg::*;
#(
    parameter int NOTE_W         = 4,
    parameter int DUR_W          = 4,
    parameter int SONG_CNT       = 4,
    parameter int SONG_LEN       = 16,
    parameter int TICKS_PER_BEAT = 25000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(SONG_CNT)-1:0] song_select,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        stop,
    output logic [NOTE_W-1:0]           note,
    output logic                        note_valid,
    output logic [$clog2(SONG_LEN)-1:0] note_idx,
    output logic                        busy,
    output logic                        end_of_song
);

    localparam int SW = $clog2(SONG_CNT);
    localparam int IW = $clog2(SONG_LEN);
    localparam int TW = TICKS_PER_BEAT > 1 ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(SONG_LEN - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BEAT - 1);

    state_t            state, state_n;
    logic [SW-1:0]     song_q, song_n;
    logic [IW-1:0]     idx, idx_n;
    logic [TW-1:0]     tick, tick_n;
    logic [DUR_W-1:0]  beats, beats_n;
    logic [NOTE_W-1:0] note_q, note_n;
    logic              valid_q, valid_n;
    logic              rom_vld;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              tick_last;

    // The ROM is addressed with the next index so a following entry is ready
    // during its single LOAD cycle; song_q only settles after start, so the
    // first LOAD of a song waits one extra cycle for rom_vld.
    song_rom #(
        .NOTE_W(NOTE_W),
        .DUR_W(DUR_W),
        .SONG_CNT(SONG_CNT),
        .SONG_LEN(SONG_LEN)
    ) u_rom (
        .clk(clk),
        .song(song_q),
        .idx(idx_n),
        .rd_note(rom_note),
        .rd_dur(rom_dur)
    );

    assign tick_last = tick == LAST_TICK;

    always_comb begin
        state_n = state;
        song_n  = song_q;
        idx_n   = idx;
        tick_n  = tick;
        beats_n = beats;
        note_n  = note_q;
        valid_n = valid_q;
        if (stop) begin
            state_n = IDLE;
            note_n  = '0;
            valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_n = LOAD;
                    song_n  = song_select;
                    idx_n   = '0;
                    tick_n  = '0;
                end
                LOAD: if (rom_vld) begin
                    state_n = rom_dur == DUR_W'(END_MARK) ? DONE : PLAY;
                    note_n  = rom_dur == DUR_W'(END_MARK) ? '0 : rom_note;
                    valid_n = rom_dur != DUR_W'(END_MARK);
                    beats_n = rom_dur;
                    tick_n  = '0;
                end
                PLAY: if (!pause) begin
                    tick_n = tick_last ? '0 : tick + 1'b1;
                    if (tick_last) beats_n = beats - 1'b1;
                    if (tick_last && beats == DUR_W'(1)) begin
                        state_n = idx == LAST_IDX ? DONE : LOAD;
                        idx_n   = idx == LAST_IDX ? idx : idx + 1'b1;
                        note_n  = idx == LAST_IDX ? '0 : note_q;
                        valid_n = idx != LAST_IDX;
                    end
                end
                DONE: begin
`ifdef SONG_SEQUENCER_LOOP_EN
                    state_n = LOAD;
                    idx_n   = '0;
`else
                    state_n = IDLE;
`endif
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            song_q  <= '0;
            idx     <= '0;
            tick    <= '0;
            beats   <= '0;
            note_q  <= '0;
            valid_q <= 1'b0;
            rom_vld <= 1'b0;
        end else begin
            state   <= state_n;
            song_q  <= song_n;
            idx     <= idx_n;
            tick    <= tick_n;
            beats   <= beats_n;
            note_q  <= note_n;
            valid_q <= valid_n;
            rom_vld <= state != IDLE;
        end
    end

    assign note        = note_q;
    assign note_valid  = valid_q && !(pause && state == PLAY);
    assign note_idx    = idx;
    assign busy        = state != IDLE;
    assign end_of_song = state == DONE;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: table vectors, directed corner sequences and random
// stimulus checked every cycle against a behavioural playback model.
module tb_song_sequencer;

    localparam int T = 4;
    localparam int L = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] song_select = 2'd0;
    logic [3:0] note;
    logic       note_valid;
    logic [3:0] note_idx;
    logic       busy;
    logic       end_of_song;

    song_sequencer #(
        .NOTE_W(4),
        .DUR_W(4),
        .SONG_CNT(4),
        .SONG_LEN(L),
        .TICKS_PER_BEAT(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .song_select(song_select),
        .start(start),
        .pause(pause),
        .stop(stop),
        .note(note),
        .note_valid(note_valid),
        .note_idx(note_idx),
        .busy(busy),
        .end_of_song(end_of_song)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {int note; int dur;} ent_t;
    ent_t songs[4][$];

    typedef struct {bit st; int sel; int n; int v; int i; int b; int e;} vec_t;
    vec_t tbl[$];

    // Model: a song is active; m_gap counts load cycles before an entry sounds,
    // m_left counts unpaused cycles left in the sounding entry.
    bit m_active, m_done, m_valid;
    int m_song, m_idx, m_gap, m_left, m_note;

    function automatic ent_t mk(int n, int d);
        ent_t x;
        x.note = n;
        x.dur = d;
        return x;
    endfunction

    function automatic ent_t entry(int s, int i);
        return (i < songs[s].size()) ? songs[s][i] : mk(0, 0);
    endfunction

    function automatic logic [10:0] pk(int n, int v, int i, int b, int e);
        return {n[3:0], v[0], i[3:0], b[0], e[0]};
    endfunction

    function automatic logic [10:0] dut_vec();
        return pk(int'(note), int'(note_valid), int'(note_idx), int'(busy), int'(end_of_song));
    endfunction

    function automatic logic [10:0] exp_vec();
        bit playing;
        playing = m_active && !m_done && m_gap == 0;
        return pk(m_note, int'(m_valid && !(pause && playing)), m_idx, int'(m_active), int'(m_done));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_valid = 0;
        m_song = 0; m_idx = 0; m_gap = 0; m_left = 0; m_note = 0;
    endtask

    task automatic step(input bit st, input bit sp, input bit ps, input int sel);
        ent_t x;
        if (sp) begin
            m_active = 0; m_done = 0; m_gap = 0; m_note = 0; m_valid = 0;
        end else if (!m_active) begin
            if (st) begin m_active = 1; m_song = sel; m_idx = 0; m_gap = 2; end
        end else if (m_done) begin
            m_done = 0;
`ifdef SONG_SEQUENCER_LOOP_EN
            m_idx = 0; m_gap = 1;
`else
            m_active = 0;
`endif
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
                x = entry(m_song, m_idx);
                if (x.dur == 0) begin m_done = 1; m_note = 0; m_valid = 0; end
                else begin m_note = x.note; m_valid = 1; m_left = x.dur * T; end
            end
        end else if (!ps) begin
            m_left--;
            if (m_left == 0) begin
                if (m_idx == L - 1) begin m_done = 1; m_note = 0; m_valid = 0; end
                else begin m_idx++; m_gap = 1; end
            end
        end
    endtask

    task automatic cyc(input bit st, input bit sp, input bit ps, input int sel);
        @(negedge clk);
        start = st; stop = sp; pause = ps; song_select = sel[1:0];
        #1;
        chk("model", int'(dut_vec()), int'(exp_vec()));
        step(st, sp, ps, sel);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
    endtask

    task automatic addv(input bit st, input int sel, input int n, input int v, input int i,
                        input int b, input int e, input int cnt);
        vec_t x;
        x.st = st; x.sel = sel; x.n = n; x.v = v; x.i = i; x.b = b; x.e = e;
        for (int k = 0; k < cnt; k++) tbl.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 0; stop = 0; pause = 0;
        rst_n = 0;
        #1;
        chk("reset_outputs", int'(dut_vec()), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int busy_cnt, mask, last_idx, wraps, adv, eos_cnt;
        bit seen, left0;
        songs[0].push_back(mk(1, 2)); songs[0].push_back(mk(3, 1)); songs[0].push_back(mk(0, 0));
        for (int i = 0; i < 16; i++) songs[1].push_back(mk((i % 14) + 1, (i % 2) + 1));
        songs[2].push_back(mk(0, 0));
        songs[3].push_back(mk(5, 1)); songs[3].push_back(mk(0, 2));
        songs[3].push_back(mk(8, 1)); songs[3].push_back(mk(0, 0));

        // Basic playback of song 0: per-cycle expected outputs (idx -1 = not checked).
        addv(1, 0, 0, 0, 0, 0, 0, 1);
        addv(0, 0, 0, 0, 0, 1, 0, 2);
        addv(0, 0, 1, 1, 0, 1, 0, 8);
        addv(0, 0, 1, 1, 1, 1, 0, 1);
        addv(0, 0, 3, 1, 1, 1, 0, 4);
        addv(0, 0, 3, 1, 2, 1, 0, 1);
        addv(0, 0, 0, 0, 2, 1, 1, 1);
        addv(0, 0, 0, 0, -1, 0, 0, 2);

        model_reset();
        #2;
        chk("reset_outputs", int'(dut_vec()), 0);
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[k]) begin
            cyc(tbl[k].st, 0, 0, tbl[k].sel);
            chk($sformatf("basic_note[%0d]", k), int'(note), tbl[k].n);
            chk($sformatf("basic_valid[%0d]", k), int'(note_valid), tbl[k].v);
            chk($sformatf("basic_busy[%0d]", k), int'(busy), tbl[k].b);
            chk($sformatf("basic_eos[%0d]", k), int'(end_of_song), tbl[k].e);
            if (tbl[k].i >= 0) chk($sformatf("basic_idx[%0d]", k), int'(note_idx), tbl[k].i);
        end

        // Pause 5 cycles during the 1-beat second note of song 0.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 12; k++) cyc(0, 0, 0, 0);
        chk("pause_pre_note", int'(note), 3);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, 0);
            chk("pause_valid", int'(note_valid), 0);
            chk("pause_note", int'(note), 3);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0);
            chk("pause_resume_valid", int'(note_valid), 1);
        end
        cyc(0, 0, 0, 0);
        chk("pause_load_idx", int'(note_idx), 2);
        chk("pause_load_eos", int'(end_of_song), 0);
        cyc(0, 0, 0, 0);
        chk("pause_eos", int'(end_of_song), 1);
        idle(2);

        // Stop during the rest entry of song 3, with start asserted alongside.
        cyc(1, 0, 0, 3);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0);
        chk("stop_pre_valid", int'(note_valid), 1);
        chk("stop_pre_idx", int'(note_idx), 1);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_valid", int'(note_valid), 0);
        chk("stop_note", int'(note), 0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0);
            seen |= end_of_song | busy;
        end
        chk("stop_no_eos_no_restart", int'(seen), 0);

        // Full 16-entry song without a marker.
        cyc(1, 0, 0, 1);
        seen = 0; last_idx = 0; wraps = 0; adv = 0; left0 = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            cyc(0, 0, 0, 0);
            if (int'(note_idx) != last_idx) adv++;
            if (int'(note_idx) < last_idx) wraps++;
            last_idx = int'(note_idx);
            seen = end_of_song;
        end
        chk("full_eos_seen", int'(seen), 1);
        chk("full_last_idx", last_idx, 15);
        chk("full_idx_steps", adv, 15);
        chk("full_no_wrap", wraps, 0);
        idle(2);

        // Empty song: end_of_song three cycles after the start cycle, no note.
        cyc(1, 0, 0, 2);
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 0);
            seen |= note_valid | end_of_song;
        end
        cyc(0, 0, 0, 0);
        chk("empty_eos", int'(end_of_song), 1);
        chk("empty_no_note", int'(seen | note_valid), 0);
        cyc(0, 0, 0, 0);
        chk("empty_idle", int'(busy), 0);

        // Start and song_select change during play are ignored.
        cyc(1, 0, 0, 0);
        busy_cnt = 0; mask = 0;
        for (int k = 1; k < 40; k++) begin
            cyc(k == 5, 0, 0, (k >= 5) ? 3 : 0);
            if (busy) busy_cnt++;
            if (note_valid) mask |= 1 << int'(note);
        end
        chk("ignore_busy_len", busy_cnt, 17);
        chk("ignore_notes", mask, 'h0a);

        // Asynchronous reset mid-song.
        cyc(1, 0, 0, 1);
        idle(20);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async_reset", int'(dut_vec()), 0);
        model_reset();
        @(negedge clk);
        start = 0;
        rst_n = 1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, 0);
            seen |= end_of_song | busy;
        end
        chk("reset_quiet", int'(seen), 0);

`ifdef SONG_SEQUENCER_LOOP_EN
        cyc(1, 0, 0, 0);
        eos_cnt = 0; seen = 0;
        for (int k = 0; k < 60; k++) begin
            cyc(0, 0, 0, 0);
            if (end_of_song) eos_cnt++;
            if (!busy) seen = 1;
        end
        chk("loop_eos_count", int'(eos_cnt >= 3), 1);
        chk("loop_busy_held", int'(seen), 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("loop_stop", int'(busy), 0);
`endif

        // Random stimulus against the model.
        do_reset();
        for (int k = 0; k < 5000; k++)
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised successor to the single-lookup song library.
- Holds SONG_CNT songs of up to SONG_LEN entries; each entry is {note code, duration in beats}.
- After a start pulse, steps autonomously through the selected song, timing each note. Supports pause, stop, and an end-of-song pulse.
- Drives the tone generator / buzzer block with a registered note code and a valid flag.

Parameters:
- NOTE_W, 4, note code width; code 0 is a rest.
- DUR_W, 4, duration field width, in beats; duration 0 is the end-of-song marker.
- SONG_CNT, 4, number of songs stored.
- SONG_LEN, 16, maximum entries per song.
- TICKS_PER_BEAT, 25000000, clk cycles per beat; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- song_select  in  $clog2(SONG_CNT)  song index, sampled only on an accepted start.
- start  in  1  pulse; begins playback when in IDLE.
- pause  in  1  level; freezes timing and silences output.
- stop  in  1  pulse; aborts playback.
- note  out  NOTE_W  current note code.
- note_valid  out  1  high while a note or rest is sounding (not paused).
- note_idx  out  $clog2(SONG_LEN)  index of the current entry.
- busy  out  1  high in every state except IDLE.
- end_of_song  out  1  one-cycle pulse on natural completion.

Behaviour:
- Clock and reset: single clk; rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; index 0; tick and beat counters 0.
- States: IDLE, LOAD, PLAY, DONE.
- IDLE: on start=1 (and stop=0), latch song_select, set index 0, go to LOAD.
- LOAD (exactly 1 cycle): issue the ROM read. The ROM output is registered and becomes valid on the next edge.
  - Then evaluate the entry. If duration==0, go to DONE. Otherwise load note/note_valid and the beat counter (=duration), and go to PLAY.
- First-note latency: start sampled at edge t gives LOAD in cycle t+1 and the note visible after edge t+2.
- PLAY timing: the tick counter counts only cycles with pause=0.
  - On reaching TICKS_PER_BEAT-1, wrap the tick counter and decrement the beat counter.
  - When the last beat expires: if index==SONG_LEN-1, go to DONE; else increment index and go to LOAD.
- Between notes: during LOAD, note and note_valid hold the previous value, so there is no glitch to 0.
- Note time: each entry occupies exactly duration*TICKS_PER_BEAT unpaused cycles in PLAY, plus 1 LOAD cycle.
- Pause: while pause=1 in PLAY, note_valid=0, note holds its value and counters freeze. Pause in other states has no effect.
- DONE (1 cycle): end_of_song=1, note=0, note_valid=0, then go to IDLE.
- Stop: from any non-IDLE state, stop=1 forces IDLE on the next edge with note=0 and note_valid=0. No end_of_song pulse.
- Stop vs start: stop wins when both are asserted in the same cycle.
- Start while busy: ignored; song_select changes mid-song are ignored.
- Empty song: if entry 0 is an end marker, end_of_song pulses 3 cycles after start and no note is emitted.
- Reset mid-operation: immediate return to reset values; no end_of_song.

Optional Feature:
- Macro: SONG_SEQUENCER_LOOP_EN.
- Defined: DONE still pulses end_of_song, then goes to LOAD with index 0 instead of IDLE. busy stays 1. Only stop or reset exits.
- Undefined: DONE goes to IDLE as specified above.

Decomposition:
- Package song_pkg:
  - state enum (IDLE/LOAD/PLAY/DONE);
  - note-code constants (REST=0, DO..SI=1..7, high octave 8..14);
  - END_MARK duration constant (0);
  - song entry struct {note, dur}.
- Sub-module song_rom:
  - synchronous-read table indexed by {song, index};
  - contents from constants in song_pkg.
- The sequencer FSM and counters live in song_sequencer.

Test Plan:
All scenarios use TICKS_PER_BEAT=4 and SONG_CNT=4.
- Basic playback: song 0 = {(1,2),(3,1),(x,0)}, start pulse. Expect:
  - note=1 valid for 8 cycles, held through LOAD;
  - note=3 for 4 cycles;
  - end_of_song pulse 1 cycle; busy drops; note=0.
- Pause: pause high for 5 cycles mid-note during a 1-beat note. Expect note_valid=0 while paused, and the note completes after 4 total unpaused cycles plus 1 cycle.
- Stop: stop during the second note. Expect IDLE next cycle, note_valid=0, no end_of_song. A start asserted in the same cycle as stop is ignored.
- Boundary: a full 16-entry song with no marker. Expect index to advance 0..15, then end_of_song; note_idx never wraps to 0 during play.
- Empty song and ignored start: song 2 entry 0 = marker gives end_of_song 3 cycles after start, with no note. A start during PLAY is ignored; song_select changed mid-song has no effect.
- Loop (SONG_SEQUENCER_LOOP_EN defined): song 0 repeats, end_of_song pulses once per pass, busy stays 1, and stop exits.
